// File: rtl/calc_pkg.sv
// Shared encodings for the sequential calculator.
// Operation codes and FSM state type.
package calc_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      ADDSUB,
      MUL,
      FINISH
   } state_e;

endpackage

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-add unsigned multiplier datapath.
// One partial product per step; W steps per product.
module seq_shift_add_mult
   import calc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           step,
   input  logic [W-1:0]   m,
   input  logic [W-1:0]   q,
   output logic [2*W-1:0] product,
   output logic           last
);

   localparam int CW = $clog2(W);

   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  mq_q, mq_d;
   logic [W-1:0]  m_q, m_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W:0]    sum;

   // load clears the accumulator; step adds and shifts right
   always_comb begin
      acc_d = acc_q;
      mq_d  = mq_q;
      m_d   = m_q;
      cnt_d = cnt_q;
      sum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? m_q : '0)};
      if (load) begin
         acc_d = '0;
         mq_d  = q;
         m_d   = m;
         cnt_d = '0;
      end else if (step) begin
         acc_d = sum[W:1];
         mq_d  = {sum[0], mq_q[W-1:1]};
         cnt_d = cnt_q + 1'b1;
      end
   end

   // datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         mq_q  <= '0;
         m_q   <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         mq_q  <= mq_d;
         m_q   <= m_d;
         cnt_q <= cnt_d;
      end
   end

   assign last    = (cnt_q == CW'(W - 1));
   assign product = {acc_q, mq_q};

endmodule

// File: rtl/seq_calc.sv
// Clocked W-bit add/sub/multiply with start/done handshake.
// Optional zero flag output: SEQ_CALC_ZERO_FLAG_EN.
module seq_calc
   import calc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [W-1:0]   x,
   input  logic [W-1:0]   y,
   input  logic [1:0]     op_sel,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] result,
   output logic           carry_out,
   output logic           overflow
`ifdef SEQ_CALC_ZERO_FLAG_EN
   ,output logic          zero
`endif
);

   state_e         state_q, state_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [2*W-1:0] result_q, result_d;
   logic           carry_q, carry_d;
   logic           ovf_q, ovf_d;
   logic [W-1:0]   x_q, x_d;
   logic [W-1:0]   y_q, y_d;
   logic [1:0]     op_q, op_d;
   logic [W-1:0]   as_sum_q, as_sum_d;
   logic           as_c_q, as_c_d;
   logic           as_v_q, as_v_d;
`ifdef SEQ_CALC_ZERO_FLAG_EN
   logic           zero_q, zero_d;
`endif

   logic           mul_load;
   logic           mul_step;
   logic           mul_last;
   logic [2*W-1:0] mul_prod;

   logic [W-1:0]   b_eff;
   logic [W:0]     as_full;

   seq_shift_add_mult #(.W(W)) u_mult (
      .clk     (clk),
      .reset   (reset),
      .load    (mul_load),
      .step    (mul_step),
      .m       (x),
      .q       (y),
      .product (mul_prod),
      .last    (mul_last)
   );

   // add/sub on captured operands; op_q[0] selects subtract
   always_comb begin
      b_eff   = y_q ^ {W{op_q[0]}};
      as_full = {1'b0, x_q} + {1'b0, b_eff} + (W+1)'(op_q[0]);
   end

   // next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      done_d   = 1'b0;
      result_d = result_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      x_d      = x_q;
      y_d      = y_q;
      op_d     = op_q;
      as_sum_d = as_sum_q;
      as_c_d   = as_c_q;
      as_v_d   = as_v_q;
      mul_load = 1'b0;
      mul_step = 1'b0;
`ifdef SEQ_CALC_ZERO_FLAG_EN
      zero_d   = zero_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               x_d      = x;
               y_d      = y;
               op_d     = op_sel;
               mul_load = 1'b1;
               state_d  = op_sel[1] ? MUL : ADDSUB;
            end
         end
         ADDSUB: begin
            as_sum_d = as_full[W-1:0];
            as_c_d   = as_full[W];
            as_v_d   = (x_q[W-1] == b_eff[W-1]) &&
                       (as_full[W-1] != x_q[W-1]);
            state_d  = FINISH;
         end
         MUL: begin
            mul_step = 1'b1;
            if (mul_last) state_d = FINISH;
         end
         FINISH: begin
            done_d = 1'b1;
            if (op_q[1]) begin
               result_d = mul_prod;
               carry_d  = 1'b0;
               ovf_d    = |mul_prod[2*W-1:W];
            end else begin
               result_d = {{W{1'b0}}, as_sum_q};
               carry_d  = as_c_q;
               ovf_d    = as_v_q;
            end
`ifdef SEQ_CALC_ZERO_FLAG_EN
            zero_d = (result_d == '0);
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         op_q     <= OP_ADD;
         as_sum_q <= '0;
         as_c_q   <= 1'b0;
         as_v_q   <= 1'b0;
`ifdef SEQ_CALC_ZERO_FLAG_EN
         zero_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         x_q      <= x_d;
         y_q      <= y_d;
         op_q     <= op_d;
         as_sum_q <= as_sum_d;
         as_c_q   <= as_c_d;
         as_v_q   <= as_v_d;
`ifdef SEQ_CALC_ZERO_FLAG_EN
         zero_q   <= zero_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;
`ifdef SEQ_CALC_ZERO_FLAG_EN
   assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_seq_calc.sv
// Directed bench for seq_calc at W=4 and W=8.
// Zero flag checked when SEQ_CALC_ZERO_FLAG_EN is defined.
module tb_seq_calc;

   logic       clk = 1'b0;
   int         n_chk = 0;
   int         n_pass = 0;

   logic       rst4 = 1'b1, st4 = 1'b0;
   logic [3:0] x4 = '0, y4 = '0;
   logic [1:0] op4 = '0;
   logic       busy4, done4, c4, v4;
   logic [7:0] res4;

   logic        rst8 = 1'b1, st8 = 1'b0;
   logic [7:0]  x8 = '0, y8 = '0;
   logic [1:0]  op8 = '0;
   logic        busy8, done8, c8, v8;
   logic [15:0] res8;
`ifdef SEQ_CALC_ZERO_FLAG_EN
   logic        z4, z8;
`endif

   always #5 clk = ~clk;

   seq_calc #(.W(4)) u_dut4 (
      .clk       (clk),
      .reset     (rst4),
      .start     (st4),
      .x         (x4),
      .y         (y4),
      .op_sel    (op4),
      .busy      (busy4),
      .done      (done4),
      .result    (res4),
      .carry_out (c4),
      .overflow  (v4)
`ifdef SEQ_CALC_ZERO_FLAG_EN
      ,.zero     (z4)
`endif
   );

   seq_calc #(.W(8)) u_dut8 (
      .clk       (clk),
      .reset     (rst8),
      .start     (st8),
      .x         (x8),
      .y         (y8),
      .op_sel    (op8),
      .busy      (busy8),
      .done      (done8),
      .result    (res8),
      .carry_out (c8),
      .overflow  (v8)
`ifdef SEQ_CALC_ZERO_FLAG_EN
      ,.zero     (z8)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run4(input string t, input logic [3:0] a, b,
                       input logic [1:0] op, input int lat,
                       input logic [7:0] er, input logic ec, ev);
      int n;
      n = 0;
      x4 = a; y4 = b; op4 = op; st4 = 1'b1;
      tick();
      st4 = 1'b0;
      check({t, "_busy"}, 32'(busy4), 32'd1);
      while (!done4 && n < 20) begin
         tick();
         n++;
      end
      check({t, "_lat"}, n, lat);
      check({t, "_res"}, 32'(res4), 32'(er));
      check({t, "_c"}, 32'(c4), 32'(ec));
      check({t, "_v"}, 32'(v4), 32'(ev));
      check({t, "_busy_at_done"}, 32'(busy4), 32'd0);
      tick();
      check({t, "_done_pulse"}, 32'(done4), 32'd0);
   endtask

   task automatic run8(input string t, input logic [7:0] a, b,
                       input logic [1:0] op, input int lat,
                       input logic [15:0] er, input logic ec, ev);
      int n;
      n = 0;
      x8 = a; y8 = b; op8 = op; st8 = 1'b1;
      tick();
      st8 = 1'b0;
      while (!done8 && n < 40) begin
         tick();
         n++;
      end
      check({t, "_lat"}, n, lat);
      check({t, "_res"}, 32'(res8), 32'(er));
      check({t, "_c"}, 32'(c8), 32'(ec));
      check({t, "_v"}, 32'(v8), 32'(ev));
      tick();
      check({t, "_done_pulse"}, 32'(done8), 32'd0);
   endtask

   initial begin
      int nd;
      logic [7:0] seen;
      // reset for 2 cycles with start asserted (must be ignored)
      st4 = 1'b1; x4 = 4'd3; y4 = 4'd3;
      tick();
      tick();
      rst4 = 1'b0; rst8 = 1'b0; st4 = 1'b0;
      check("rst_busy", 32'(busy4), 32'd0);
      check("rst_done", 32'(done4), 32'd0);
      check("rst_res", 32'(res4), 32'd0);
      check("rst_c", 32'(c4), 32'd0);
      check("rst_v", 32'(v4), 32'd0);
      tick();
      check("rst_start_ignored", 32'(busy4), 32'd0);
      check("rst8_res", 32'(res8), 32'd0);

      run4("add_7_9", 4'd7, 4'd9, 2'b00, 2, 8'h00, 1'b1, 1'b0);
      run4("add_7_1", 4'd7, 4'd1, 2'b00, 2, 8'h08, 1'b0, 1'b1);
      run4("sub_3_5", 4'd3, 4'd5, 2'b01, 2, 8'h0E, 1'b0, 1'b0);
      run4("sub_5_3", 4'd5, 4'd3, 2'b01, 2, 8'h02, 1'b1, 1'b0);
      run4("sub_8_1", 4'd8, 4'd1, 2'b01, 2, 8'h07, 1'b1, 1'b1);
      run4("mul_15_15", 4'd15, 4'd15, 2'b10, 5, 8'hE1, 1'b0, 1'b1);
      run4("mul_3_5", 4'd3, 4'd5, 2'b11, 5, 8'h0F, 1'b0, 1'b0);
      check("hold_res", 32'(res4), 32'h0F);

      // start while multiplying is dropped
      x4 = 4'd15; y4 = 4'd15; op4 = 2'b10; st4 = 1'b1;
      tick();
      st4 = 1'b0;
      tick();
      x4 = 4'd1; y4 = 4'd1; op4 = 2'b00; st4 = 1'b1;
      tick();
      st4 = 1'b0;
      nd = 0;
      seen = '0;
      for (int i = 0; i < 10; i++) begin
         if (done4) begin
            nd++;
            seen = res4;
         end
         tick();
      end
      check("busy_ignore_dones", nd, 1);
      check("busy_ignore_res", 32'(seen), 32'hE1);
      check("busy_ignore_hold", 32'(res4), 32'hE1);

      // W=8: reset aborts a multiply
      x8 = 8'd255; y8 = 8'd255; op8 = 2'b10; st8 = 1'b1;
      tick();
      st8 = 1'b0;
      nd = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done8) nd++;
      end
      rst8 = 1'b1;
      tick();
      rst8 = 1'b0;
      check("abort_busy", 32'(busy8), 32'd0);
      check("abort_res", 32'(res8), 32'd0);
      for (int i = 0; i < 12; i++) begin
         if (done8) nd++;
         tick();
      end
      check("abort_no_done", nd, 0);
      check("abort_res_hold", 32'(res8), 32'd0);

      run8("mul8_200_3", 8'd200, 8'd3, 2'b10, 9, 16'h0258, 1'b0, 1'b1);
`ifdef SEQ_CALC_ZERO_FLAG_EN
      check("zero_nz", 32'(z8), 32'd0);
`endif
      run8("add8_255_1", 8'd255, 8'd1, 2'b00, 2, 16'h0000, 1'b1, 1'b0);
      run8("mul8_0_77", 8'd0, 8'd77, 2'b10, 9, 16'h0000, 1'b0, 1'b0);
`ifdef SEQ_CALC_ZERO_FLAG_EN
      check("zero_set", 32'(z8), 32'd1);
      check("zero4_clear", 32'(z4), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
